// File: rtl/buzzer_seq_if.sv
// Host-control and DMA-read signal bundle for the buzzer script sequencer.
// The slave modport is the sequencer's view; master is the host/memory side.
interface buzzer_seq_if;
   logic        go;
   logic [15:0] baseAddr;
   logic        halt;
   logic        busy;
   logic        cmdStart;
   logic [23:0] cmdOut;
   logic        startDMA;
   logic [15:0] addrDMA;
   logic [15:0] fromMemDMA;
   logic        rdyDMA;

   modport slave (
      input  go, baseAddr, halt, fromMemDMA, rdyDMA,
      output busy, cmdStart, cmdOut, startDMA, addrDMA
   );

   modport master (
      output go, baseAddr, halt, fromMemDMA, rdyDMA,
      input  busy, cmdStart, cmdOut, startDMA, addrDMA
   );
endinterface

// File: rtl/buzzer_seq.sv
// Script player: fetches two-word records over a single-outstanding DMA port
// and turns them into buzzer commands, timed waits, jumps or end-of-script.
module buzzer_seq #(
   parameter int TICK_DIV = 50000
) (
   input  logic           clk,
   input  logic           rst,
   buzzer_seq_if.slave    bus
);

   localparam int              PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]      OP_WAIT   = 8'hF0;
   localparam logic [7:0]      OP_JUMP   = 8'hF1;
   localparam logic [7:0]      OP_END    = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_A,
      S_WAIT_A,
      S_REQ_B,
      S_WAIT_B,
      S_DECODE,
      S_DELAY
   } state_t;

   state_t         r_state,    w_state_next;
   logic [15:0]    r_ptr,      w_ptr_next;
   logic [15:0]    r_count,    w_count_next;
   logic [PW-1:0]  r_presc,    w_presc_next;
   logic [7:0]     r_opcode,   w_opcode_next;
   logic [15:0]    r_arg,      w_arg_next;
   logic [23:0]    r_cmd_hold, w_cmd_hold_next;
   logic           w_cmd_start;
   logic           w_start_dma;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_count    <= '0;
         r_presc    <= '0;
         r_opcode   <= '0;
         r_arg      <= '0;
         r_cmd_hold <= '0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_count    <= w_count_next;
         r_presc    <= w_presc_next;
         r_opcode   <= w_opcode_next;
         r_arg      <= w_arg_next;
         r_cmd_hold <= w_cmd_hold_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_count_next    = r_count;
      w_presc_next    = r_presc;
      w_opcode_next   = r_opcode;
      w_arg_next      = r_arg;
      w_cmd_hold_next = r_cmd_hold;
      w_cmd_start     = 1'b0;
      w_start_dma     = 1'b0;

      // halt wins over everything, including a same-cycle go or rdyDMA
      if (bus.halt) begin
         w_state_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  w_ptr_next   = bus.baseAddr;
                  w_presc_next = '0;
                  w_state_next = S_REQ_A;
               end
            end
            S_REQ_A: begin
               w_start_dma  = 1'b1;
               w_state_next = S_WAIT_A;
            end
            S_WAIT_A: begin
               if (bus.rdyDMA) begin
                  w_opcode_next = bus.fromMemDMA[15:8];
                  w_ptr_next    = r_ptr + 16'd1;
                  w_state_next  = S_REQ_B;
               end
            end
            S_REQ_B: begin
               w_start_dma  = 1'b1;
               w_state_next = S_WAIT_B;
            end
            S_WAIT_B: begin
               if (bus.rdyDMA) begin
                  w_arg_next   = bus.fromMemDMA;
                  w_ptr_next   = r_ptr + 16'd1;
                  w_state_next = S_DECODE;
               end
            end
            S_DECODE: begin
               unique case (r_opcode)
                  OP_WAIT: begin
                     if (r_arg == 16'd0) begin
                        w_state_next = S_REQ_A;
                     end else begin
                        w_count_next = r_arg;
                        w_state_next = S_DELAY;
                     end
                  end
                  OP_JUMP: begin
                     w_ptr_next   = r_arg;
                     w_state_next = S_REQ_A;
                  end
                  OP_END: begin
                     w_state_next = S_IDLE;
                  end
                  default: begin
                     w_cmd_start     = 1'b1;
                     w_cmd_hold_next = {r_opcode, r_arg};
                     w_state_next    = S_REQ_A;
                  end
               endcase
            end
            S_DELAY: begin
               // prescaler wraps back to 0 so the next DELAY starts aligned
               if (r_presc == PRESC_MAX) begin
                  w_presc_next = '0;
                  w_count_next = r_count - 16'd1;
                  if (r_count == 16'd1) begin
                     w_state_next = S_REQ_A;
                  end
               end else begin
                  w_presc_next = r_presc + 1'b1;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.cmdStart = w_cmd_start;
   assign bus.cmdOut   = w_cmd_start ? {r_opcode, r_arg} : r_cmd_hold;
   assign bus.startDMA = w_start_dma;
   assign bus.addrDMA  = r_ptr;

endmodule

// File: tb/tb_buzzer_seq.sv
// Scoreboard bench for buzzer_seq: memory responder, output monitor, and
// one task per scenario; expected commands are queued when stimulus is set up.
module tb_buzzer_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   buzzer_seq_if bus ();

   buzzer_seq #(.TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [0:65535];

   int n_pass  = 0;
   int n_total = 0;

   logic        resp_en   = 1'b1;
   logic        resp_rdy  = 1'b0;
   logic [15:0] resp_data = '0;
   logic        man_rdy   = 1'b0;
   logic [15:0] man_data  = '0;

   assign bus.rdyDMA     = resp_en ? resp_rdy  : man_rdy;
   assign bus.fromMemDMA = resp_en ? resp_data : man_data;

   logic [23:0] exp_q[$];
   logic [15:0] addr_q[$];
   int          start_cyc_q[$];
   int          rdy_cyc_q[$];
   int          dma_cnt = 0;
   int          cmd_cnt = 0;
   int          cyc     = 0;

   // memory responder: answers each startDMA one cycle later
   initial begin
      int          cnt;
      logic [15:0] a;
      cnt = -1;
      a   = '0;
      forever begin
         @(negedge clk);
         resp_rdy = 1'b0;
         if (cnt > 0) cnt--;
         if (cnt == 0) begin
            resp_data = mem[a];
            resp_rdy  = 1'b1;
            cnt       = -1;
         end else if (cnt < 0 && resp_en && bus.startDMA) begin
            a   = bus.addrDMA;
            cnt = 1;
         end
      end
   end

   // output monitor and command scoreboard
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus.startDMA === 1'b1) begin
            dma_cnt++;
            addr_q.push_back(bus.addrDMA);
            start_cyc_q.push_back(cyc);
         end
         if (bus.rdyDMA === 1'b1) rdy_cyc_q.push_back(cyc);
         if (bus.cmdStart === 1'b1) begin
            cmd_cnt++;
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL cmd_unexpected: got cmdOut=%06h, expected no strobe", bus.cmdOut);
            end else begin
               e = exp_q.pop_front();
               if (bus.cmdOut !== e)
                  $display("FAIL cmd_value: got cmdOut=%06h, expected %06h", bus.cmdOut, e);
               else begin
                  n_pass++;
                  $display("cmd %06h ok", bus.cmdOut);
               end
            end
         end
      end
   end

   task automatic clear_stats();
      exp_q.delete();
      addr_q.delete();
      start_cyc_q.delete();
      rdy_cyc_q.delete();
      dma_cnt = 0;
      cmd_cnt = 0;
   endtask

   task automatic pulse_go(input logic [15:0] base);
      @(negedge clk);
      bus.go       = 1'b1;
      bus.baseAddr = base;
      @(negedge clk);
      bus.go       = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n;
      n = 0;
      while (bus.busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
      else n_pass++;
      repeat (2) @(negedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", bus.busy); else n_pass++;
      n_total++; if (bus.cmdStart !== 1'b0) $display("FAIL rst_cmdStart: got %b, expected 0", bus.cmdStart); else n_pass++;
      n_total++; if (bus.cmdOut !== 24'h0) $display("FAIL rst_cmdOut: got %06h, expected 000000", bus.cmdOut); else n_pass++;
      n_total++; if (bus.startDMA !== 1'b0) $display("FAIL rst_startDMA: got %b, expected 0", bus.startDMA); else n_pass++;
      n_total++; if (bus.addrDMA !== 16'h0) $display("FAIL rst_addrDMA: got %04h, expected 0000", bus.addrDMA); else n_pass++;
      $display("reset state checked");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_cmd();
      clear_stats();
      mem[16'h0100] = 16'h0100; mem[16'h0101] = 16'h0025;
      mem[16'h0102] = 16'hFF00; mem[16'h0103] = 16'h0000;
      exp_q.push_back(24'h010025);
      pulse_go(16'h0100);
      wait_idle(200, "single");
      n_total++; if (cmd_cnt != 1) $display("FAIL single_cmd_count: got %0d, expected 1", cmd_cnt); else n_pass++;
      n_total++; if (dma_cnt != 4) $display("FAIL single_dma_count: got %0d, expected 4", dma_cnt); else n_pass++;
      n_total++; if (bus.cmdOut !== 24'h010025) $display("FAIL single_cmd_hold: got %06h, expected 010025", bus.cmdOut); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL single_pending: got %0d left, expected 0", exp_q.size()); else n_pass++;
      $display("single command: %0d dma, %0d cmd", dma_cnt, cmd_cnt);
   endtask

   task automatic test_wait_delay();
      int args[3] = '{0, 1, 3};
      int gap;
      foreach (args[k]) begin
         clear_stats();
         mem[16'h0200] = 16'hF000; mem[16'h0201] = 16'(args[k]);
         mem[16'h0202] = 16'hFF00; mem[16'h0203] = 16'h0000;
         pulse_go(16'h0200);
         wait_idle(300, "wait");
         gap = (start_cyc_q.size() > 2 && rdy_cyc_q.size() > 1) ? start_cyc_q[2] - rdy_cyc_q[1] : -1;
         n_total++;
         if (gap != 2 + 4 * args[k]) $display("FAIL wait_gap_arg%0d: got %0d cycles, expected %0d", args[k], gap, 2 + 4 * args[k]);
         else n_pass++;
         n_total++; if (cmd_cnt != 0) $display("FAIL wait_cmd_arg%0d: got %0d strobes, expected 0", args[k], cmd_cnt); else n_pass++;
         $display("wait arg=%0d: rdy-to-fetch gap %0d cycles", args[k], gap);
      end
   endtask

   task automatic test_jump_loop();
      int n;
      clear_stats();
      mem[16'h0100] = 16'h0100; mem[16'h0101] = 16'h0025;
      mem[16'h0102] = 16'h0200; mem[16'h0103] = 16'h0077;
      mem[16'h0104] = 16'hF100; mem[16'h0105] = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(24'h010025);
         exp_q.push_back(24'h020077);
      end
      pulse_go(16'h0100);
      n = 0;
      while (cmd_cnt < 6 && n < 500) begin
         @(negedge clk);
         n++;
      end
      n_total++; if (cmd_cnt < 6) $display("FAIL jump_loop_timeout: got %0d strobes, expected 6", cmd_cnt); else n_pass++;
      bus.halt = 1'b1;
      @(negedge clk);
      bus.halt = 1'b0;
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL jump_halt_busy: got %b, expected 0", bus.busy); else n_pass++;
      n_total++;
      if (addr_q.size() < 7 || addr_q[5] !== 16'h0105 || addr_q[6] !== 16'h0100)
         $display("FAIL jump_addr: got fetch[6]=%04h, expected 0100 after 0105", addr_q.size() > 6 ? addr_q[6] : 16'hxxxx);
      else n_pass++;
      repeat (3) @(negedge clk);
      #2;
      n_total++; if (exp_q.size() != 0) $display("FAIL jump_pending: got %0d left, expected 0", exp_q.size()); else n_pass++;
      $display("jump loop: %0d strobes, %0d fetches", cmd_cnt, dma_cnt);
   endtask

   task automatic test_halt_wait_b();
      int n;
      clear_stats();
      resp_en = 1'b0;
      mem[16'h0300] = 16'h0500; mem[16'h0301] = 16'h1234;
      pulse_go(16'h0300);
      n = 0;
      while (!bus.startDMA && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      man_data = mem[16'h0300]; man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0;
      n = 0;
      while (!bus.startDMA && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      bus.halt = 1'b1;
      @(negedge clk);
      bus.halt = 1'b0;
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL haltb_busy: got %b, expected 0", bus.busy); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      man_data = mem[16'h0301]; man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL haltb_late_rdy: busy=%b, expected 0", bus.busy); else n_pass++;
      n_total++; if (cmd_cnt != 0) $display("FAIL haltb_cmd: got %0d strobes, expected 0", cmd_cnt); else n_pass++;
      n_total++; if (dma_cnt != 2) $display("FAIL haltb_dma: got %0d fetches, expected 2", dma_cnt); else n_pass++;
      resp_en = 1'b1;
      $display("halt in WAIT_B: busy=%b, %0d fetches", bus.busy, dma_cnt);
   endtask

   task automatic test_addr_wrap();
      clear_stats();
      mem[16'hFFFE] = 16'h0300; mem[16'hFFFF] = 16'h0005;
      mem[16'h0000] = 16'hFF00; mem[16'h0001] = 16'h0000;
      exp_q.push_back(24'h030005);
      pulse_go(16'hFFFE);
      wait_idle(200, "wrap");
      n_total++;
      if (addr_q.size() < 3 || addr_q[2] !== 16'h0000)
         $display("FAIL wrap_addr: got fetch[2]=%04h, expected 0000", addr_q.size() > 2 ? addr_q[2] : 16'hxxxx);
      else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL wrap_pending: got %0d left, expected 0", exp_q.size()); else n_pass++;
      $display("address wrap: %0d fetches", dma_cnt);
   endtask

   task automatic test_reset_in_delay();
      clear_stats();
      mem[16'h0400] = 16'hF000; mem[16'h0401] = 16'd100;
      mem[16'h0402] = 16'hFF00; mem[16'h0403] = 16'h0000;
      pulse_go(16'h0400);
      repeat (20) @(negedge clk);
      n_total++; if (bus.busy !== 1'b1) $display("FAIL rstd_in_delay: busy=%b, expected 1", bus.busy); else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL rstd_busy: got %b, expected 0", bus.busy); else n_pass++;
      n_total++; if (bus.cmdOut !== 24'h0) $display("FAIL rstd_cmdOut: got %06h, expected 000000", bus.cmdOut); else n_pass++;
      n_total++; if (bus.addrDMA !== 16'h0) $display("FAIL rstd_addrDMA: got %04h, expected 0000", bus.addrDMA); else n_pass++;
      n_total++; if (bus.startDMA !== 1'b0 || bus.cmdStart !== 1'b0)
         $display("FAIL rstd_strobes: got startDMA=%b cmdStart=%b, expected 0 0", bus.startDMA, bus.cmdStart);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      mem[16'h0500] = 16'h0700; mem[16'h0501] = 16'h0042;
      mem[16'h0502] = 16'hFF00; mem[16'h0503] = 16'h0000;
      exp_q.push_back(24'h070042);
      pulse_go(16'h0500);
      wait_idle(200, "restart");
      n_total++;
      if (addr_q.size() < 1 || addr_q[0] !== 16'h0500)
         $display("FAIL restart_addr: got fetch[0]=%04h, expected 0500", addr_q.size() > 0 ? addr_q[0] : 16'hxxxx);
      else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL restart_pending: got %0d left, expected 0", exp_q.size()); else n_pass++;
      $display("reset in delay then restart: %0d fetches", dma_cnt);
   endtask

   initial begin
      bus.go       = 1'b0;
      bus.halt     = 1'b0;
      bus.baseAddr = '0;
      test_reset();
      test_single_cmd();
      test_wait_delay();
      test_jump_loop();
      test_halt_wait_b();
      test_addr_wrap();
      test_reset_in_delay();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
